// File: rtl/wb_bus_pkg.sv
//==============================================================================
// Module   : wb_bus_pkg
// Purpose  : Peripheral-segment Wishbone constants and arbiter state encoding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_bus_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  localparam logic [31:0] GPIO_MEM_ADDR   = 32'h8000_1000;
  localparam logic [31:0] GPIO_IDR_OFFSET = 32'h0000_0000;
  localparam logic [31:0] GPIO_ODR_OFFSET = 32'h0000_0004;

  // Read data returned to a master whose cycle had to be terminated.
  localparam logic [31:0] WB_BUS_ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//==============================================================================
// Module   : rr_pick
// Purpose  : Round-robin pick: first request after last_idx, one-hot + index.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_idx,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [IDX_W-1:0] cand;

  // Scan starts one past the previous owner, so the previous owner comes last.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(last_idx) + i) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
//==============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Round-robin Wishbone classic arbiter, whole cyc-framed ownership.
//            Optional stalled-strobe timeout enabled by WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  input  logic [DATA_W-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]       r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]       r_last_idx, w_last_idx_nxt;

  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;

  logic                   w_busy;
  logic                   w_own_cyc;
  logic                   w_own_stb;
  logic                   w_timeout;

  logic [ADDR_W-1:0]      w_adr_arr [NUM_MASTERS];
  logic [DATA_W-1:0]      w_dat_arr [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign w_adr_arr[gi] = m_adr_i[gi*ADDR_W +: ADDR_W];
    assign w_dat_arr[gi] = m_dat_i[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req      (m_cyc_i),
    .last_idx (r_last_idx),
    .grant    (w_pick_grant),
    .idx      (w_pick_idx),
    .valid    (w_pick_valid)
  );

  // Outputs are masked while rst is high so an aborted transfer never acks.
  assign w_busy    = (r_state == BUSY) && !rst;
  assign w_own_cyc = m_cyc_i[r_gidx];
  assign w_own_stb = m_stb_i[r_gidx];
  assign grant_o   = rst ? '0 : r_grant;
  assign timeout_o = w_timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic            w_stall;

  assign w_stall   = w_busy && w_own_cyc && w_own_stb && !s_ack_i;
  assign w_timeout = w_stall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_to_cnt_nxt = '0;
    if (w_stall && !w_timeout) begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`else
  // No counter: a silent slave stalls the owner; the limit has no effect.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_last_idx_nxt = r_last_idx;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    s_we_o         = 1'b0;
    s_adr_o        = '0;
    s_dat_o        = '0;
    m_ack_o        = '0;
    m_dat_o        = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick_grant;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      BUSY: begin
        if (w_busy) begin
          s_cyc_o = w_own_cyc;
          s_stb_o = w_own_stb && !w_timeout;
          s_we_o  = m_we_i[r_gidx];
          s_adr_o = w_adr_arr[r_gidx];
          s_dat_o = w_dat_arr[r_gidx];
          m_dat_o = w_timeout ? DATA_W'(WB_BUS_ERR_DATA) : s_dat_i;
          // A stray slave ack after the owner dropped stb is not forwarded.
          if (w_own_cyc && w_own_stb && (s_ack_i || w_timeout)) begin
            m_ack_o = r_grant;
          end
        end
        if (!w_own_cyc) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_last_idx_nxt = r_gidx;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_last_idx <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_last_idx <= w_last_idx_nxt;
    end
  end

endmodule

`default_nettype wire
